axi_wr_slave_burst: RTL and testbench
=====================================

Name: axi_wr_slave_burst

Overview:
Parametrised AXI3 write-slave front end that accepts one write burst at a time. It generates per-beat byte addresses for FIXED, INCR and WRAP bursts of any legal AWSIZE. Each beat, with its strobes, is handed to a local device over a valid/ready port. The block returns a proper BVALID/BREADY response, including SLVERR on protocol violations; it sits between the interconnect write channels and a memory or register device.

Parameters:
DATA_W, 32, data bus width in bits (power of two, 8..128)
ADDR_W, 32, address width
ID_W, 2, transaction ID width

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
AWID  in  ID_W  write address ID
AWADDR  in  ADDR_W  burst start byte address
AWLEN  in  4  beats minus one
AWSIZE  in  3  log2 bytes per beat
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
AWLOCK/AWCACHE/AWPROT  in  2/4/3  accepted, ignored
AWVALID  in  1  address valid
AWREADY  out  1  address ready
WID  in  ID_W  write data ID
WDATA  in  DATA_W  write data
WSTRB  in  DATA_W/8  byte strobes
WLAST  in  1  last beat
WVALID  in  1  data valid
WREADY  out  1  data ready
BID  out  ID_W  response ID
BRESP  out  2  00 OKAY, 10 SLVERR
BVALID  out  1  response valid
BREADY  in  1  response ready
dev_addr  out  ADDR_W  beat byte address
dev_data  out  DATA_W  beat data
dev_strb  out  DATA_W/8  beat strobes
dev_valid  out  1  beat offered to device
dev_ready  in  1  device accepted beat

Behaviour:
- Reset (async assert, sync release): state IDLE; AWREADY=1 and every other output 0, including BID, BRESP, dev_*.
- All outputs are registered. No combinational path exists from an input to an output.
- IDLE:
  - AWREADY=1.
  - On AWVALID: latch ID, AWADDR, AWLEN, AWSIZE, AWBURST; clear beat_cnt and err; drop AWREADY; go to DATA.
  - AWSIZE > log2(DATA_W/8) or AWBURST=11 sets err.
  - WRAP with AWLEN not in {1,3,7,15}, or with an unaligned address, sets err.
- DATA:
  - WREADY=1.
  - On WVALID: capture WDATA/WSTRB and the current address into dev_*; drop WREADY.
  - WID != latched ID: set err, keep dev_valid=0, go to ADV.
  - Otherwise: set dev_valid=1, go to DEV.
- DEV:
  - Hold dev_* stable until dev_ready, then clear dev_valid and go to ADV.
  - A device write therefore takes at least 2 cycles per beat.
- ADV (1 cycle): compute the next address, then branch.
  - last = (beat_cnt == latched AWLEN).
  - WLAST != last on the captured beat: set err.
  - last or WLAST: go to RESP.
  - Otherwise: beat_cnt+1, WREADY=1, go to DATA.
- Address stepping, with size = 1<<AWSIZE:
  - FIXED: address unchanged.
  - INCR: addr + size. Crossing a 4 KB boundary is not checked; the address wraps modulo 2^ADDR_W.
  - WRAP: with span = (AWLEN+1)*size, low bits follow (addr+size) mod span within the span-aligned base.
- RESP:
  - BVALID=1, BID=latched ID, BRESP = err ? SLVERR : OKAY.
  - Hold until BREADY is sampled high, then clear BVALID, set AWREADY=1, go to IDLE.
  - BREADY already high on BVALID's first cycle gives a 1-cycle response.
- Erroneous bursts still consume every W beat; device writes are suppressed only for mismatched-WID beats.
- Reset mid-burst aborts with no response; a device beat in flight is abandoned (dev_valid drops immediately).

Decomposition:
- Package axi_pkg:
  - BURST_FIXED/INCR/WRAP and RESP_OKAY/SLVERR constants.
  - State encoding IDLE/DATA/DEV/ADV/RESP.
- Sub-module axi_burst_addr_gen: combinational next-address logic from (addr, size, len, burst), sized by ADDR_W.

Test Plan:
- INCR: AWADDR=0x100, AWLEN=3, AWSIZE=2, dev_ready tied 1 -> dev_addr 0x100,0x104,0x108,0x10C; BRESP=00; BID=AWID.
- WRAP: AWADDR=0x38, AWLEN=3, AWSIZE=2 -> dev_addr 0x38,0x3C,0x30,0x34; OKAY.
- FIXED: AWADDR=0x20, AWLEN=2, with dev_ready stalled 3 cycles on beat 1 -> all beats at 0x20; dev_data stable throughout the stall; WREADY low during the stall.
- Errors: WLAST on beat 1 of AWLEN=3 -> burst ends, BRESP=10. WID=1 vs AWID=2 on one beat -> that beat not written, BRESP=10.
- Response handshake: BREADY held low 5 cycles -> BVALID, BID and BRESP stable; a new AWVALID is not accepted until one cycle after BREADY.
- Reset: ARESETn low mid-DEV -> dev_valid, WREADY, BVALID drop immediately; AWREADY=1 after release.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared constants and FSM encoding for the AXI3 burst write slave.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_DEV,
    ST_ADV,
    ST_RESP
  } state_t;

  // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next beat address for FIXED / INCR / WRAP bursts; purely combinational.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_size,
  input  logic [3:0]        i_len,
  input  logic [1:0]        i_burst,
  output logic [ADDR_W-1:0] o_next_addr
);

  logic [ADDR_W-1:0] w_size_bytes;
  logic [ADDR_W-1:0] w_incr;
  logic [ADDR_W-1:0] w_span_mask;

  always_comb begin
    w_size_bytes = ADDR_W'(1) << i_size;
    w_incr       = i_addr + w_size_bytes;
    // span is a power of two for every legal WRAP length, so a mask does the modulo
    w_span_mask  = ((ADDR_W'(i_len) + ADDR_W'(1)) << i_size) - ADDR_W'(1);
    case (i_burst)
      BURST_FIXED: o_next_addr = i_addr;
      BURST_INCR:  o_next_addr = w_incr;
      BURST_WRAP:  o_next_addr = (i_addr & ~w_span_mask) | (w_incr & w_span_mask);
      default:     o_next_addr = i_addr;
    endcase
  end

endmodule

// File: rtl/axi_wr_slave_burst.sv
// AXI3 write slave: one burst at a time, each beat forwarded to a local device port.
//  state   | meaning
//  IDLE    | AWREADY high, waiting for a write address
//  DATA    | WREADY high, waiting for the next W beat
//  DEV     | beat offered on dev_*, waiting for dev_ready
//  ADV     | step address, check WLAST, pick next beat or response
//  RESP    | BVALID high until BREADY
module axi_wr_slave_burst
  import axi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 2
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic [1:0]          AWLOCK,
  input  logic [3:0]          AWCACHE,
  input  logic [2:0]          AWPROT,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [ID_W-1:0]     WID,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  output logic [ADDR_W-1:0]   dev_addr,
  output logic [DATA_W-1:0]   dev_data,
  output logic [DATA_W/8-1:0] dev_strb,
  output logic                dev_valid,
  input  logic                dev_ready
);

  localparam int         STRB_W   = DATA_W / 8;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_W));

  state_t              r_state;
  logic [ID_W-1:0]     r_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_len;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic [3:0]          r_beat_cnt;
  logic                r_err;
  logic                r_wlast;

  logic                r_awready;
  logic                r_wready;
  logic                r_bvalid;
  logic [ID_W-1:0]     r_bid;
  logic [1:0]          r_bresp;
  logic [ADDR_W-1:0]   r_dev_addr;
  logic [DATA_W-1:0]   r_dev_data;
  logic [STRB_W-1:0]   r_dev_strb;
  logic                r_dev_valid;

  logic [ADDR_W-1:0]   w_next_addr;
  logic [ADDR_W-1:0]   w_align_mask;
  logic                w_aw_err;
  logic                w_last;
  logic                w_err_final;
  logic                w_unused;

  assign w_unused = ^{AWLOCK, AWCACHE, AWPROT};

  always_comb begin
    w_align_mask = (ADDR_W'(1) << AWSIZE) - ADDR_W'(1);
    w_aw_err     = (AWSIZE > MAX_SIZE) || (AWBURST == 2'b11) ||
                   ((AWBURST == BURST_WRAP) &&
                    (!wrap_len_ok(AWLEN) || ((AWADDR & w_align_mask) != '0)));
    w_last       = (r_beat_cnt == r_len);
    // folds this beat's WLAST check into the response decided in the same cycle
    w_err_final  = r_err || (r_wlast != w_last);
  end

  axi_burst_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_addr      (r_addr),
    .i_size      (r_size),
    .i_len       (r_len),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state     <= ST_IDLE;
      r_id        <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_size      <= '0;
      r_burst     <= '0;
      r_beat_cnt  <= '0;
      r_err       <= 1'b0;
      r_wlast     <= 1'b0;
      r_awready   <= 1'b1;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bid       <= '0;
      r_bresp     <= RESP_OKAY;
      r_dev_addr  <= '0;
      r_dev_data  <= '0;
      r_dev_strb  <= '0;
      r_dev_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (AWVALID) begin
            r_id       <= AWID;
            r_addr     <= AWADDR;
            r_len      <= AWLEN;
            r_size     <= AWSIZE;
            r_burst    <= AWBURST;
            r_beat_cnt <= '0;
            r_err      <= w_aw_err;
            r_awready  <= 1'b0;
            r_wready   <= 1'b1;
            r_state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (WVALID) begin
            r_dev_addr <= r_addr;
            r_dev_data <= WDATA;
            r_dev_strb <= WSTRB;
            r_wlast    <= WLAST;
            r_wready   <= 1'b0;
            if (WID != r_id) begin
              r_err   <= 1'b1;
              r_state <= ST_ADV;
            end else begin
              r_dev_valid <= 1'b1;
              r_state     <= ST_DEV;
            end
          end
        end
        ST_DEV: begin
          if (dev_ready) begin
            r_dev_valid <= 1'b0;
            r_state     <= ST_ADV;
          end
        end
        ST_ADV: begin
          r_addr <= w_next_addr;
          r_err  <= w_err_final;
          if (w_last || r_wlast) begin
            r_bvalid <= 1'b1;
            r_bid    <= r_id;
            r_bresp  <= w_err_final ? RESP_SLVERR : RESP_OKAY;
            r_state  <= ST_RESP;
          end else begin
            r_beat_cnt <= r_beat_cnt + 4'd1;
            r_wready   <= 1'b1;
            r_state    <= ST_DATA;
          end
        end
        ST_RESP: begin
          if (BREADY) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign AWREADY   = r_awready;
  assign WREADY    = r_wready;
  assign BVALID    = r_bvalid;
  assign BID       = r_bid;
  assign BRESP     = r_bresp;
  assign dev_addr  = r_dev_addr;
  assign dev_data  = r_dev_data;
  assign dev_strb  = r_dev_strb;
  assign dev_valid = r_dev_valid;

endmodule

// File: tb/tb_axi_wr_slave_burst.sv
// Directed and randomized bursts checked against an arithmetic burst/response model.
module tb_axi_wr_slave_burst;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [1:0]  AWID = '0;
  logic [31:0] AWADDR = '0;
  logic [3:0]  AWLEN = '0;
  logic [2:0]  AWSIZE = '0;
  logic [1:0]  AWBURST = '0;
  logic [1:0]  AWLOCK = '0;
  logic [3:0]  AWCACHE = '0;
  logic [2:0]  AWPROT = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [1:0]  WID = '0;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WLAST = 1'b0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [31:0] dev_addr;
  logic [31:0] dev_data;
  logic [3:0]  dev_strb;
  logic        dev_valid;
  logic        dev_ready;

  logic        rdy_force = 1'b0;
  logic        rand_en = 1'b0;
  logic        rdy_rand = 1'b1;
  assign dev_ready = rdy_force ? 1'b0 : rdy_rand;

  always #5 ACLK = ~ACLK;

  axi_wr_slave_burst #(.DATA_W(32), .ADDR_W(32), .ID_W(2)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .dev_addr(dev_addr), .dev_data(dev_data), .dev_strb(dev_strb),
    .dev_valid(dev_valid), .dev_ready(dev_ready)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;

  beat_t got_q[$];
  beat_t exp_q[$];

  always @(negedge ACLK)
    if (dev_valid && dev_ready) got_q.push_back('{dev_addr, dev_data, dev_strb});

  initial forever begin
    @(posedge ACLK);
    #1;
    rdy_rand = rand_en ? 1'($urandom) : 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return AWREADY;
      1:       return WREADY;
      2:       return BVALID;
      default: return dev_valid;
    endcase
  endfunction

  task automatic wait_for(input int w, input string tag);
    int n = 0;
    @(negedge ACLK);
    while (!sig(w) && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    chk({tag, "_wait"}, 64'(sig(w)), 64'd1);
  endtask

  // Address of beat i, straight from the burst-type definitions.
  function automatic logic [31:0] model_addr(input logic [31:0] a, input int sz,
                                             input int len, input int bt, input int i);
    longint unsigned step, span, base, start;
    step  = longint'(1) << sz;
    span  = longint'(len + 1) * step;
    start = longint'(a);
    case (bt)
      0: return a;
      1: return 32'(start + longint'(i) * step);
      default: begin
        base = start - (start % span);
        return 32'(base + ((start - base + longint'(i) * step) % span));
      end
    endcase
  endfunction

  task automatic do_burst(input logic [1:0] id, input logic [31:0] addr, input int len,
                          input int size, input int bt, input int bad_beat,
                          input int wlast_beat, input int bready_dly, input int stall_beat,
                          input bit chk_addr, input string tag);
    int nb;
    bit err;
    nb  = ((wlast_beat < len) ? wlast_beat : len) + 1;
    err = (size > 2) || (bt == 3) || (wlast_beat != len) || (bad_beat >= 0 && bad_beat < nb);
    if (bt == 2 && (!(len inside {1, 3, 7, 15}) || (longint'(addr) % (longint'(1) << size)) != 0))
      err = 1'b1;
    got_q.delete();
    exp_q.delete();

    @(posedge ACLK); #1;
    AWVALID = 1'b1; AWID = id; AWADDR = addr;
    AWLEN = 4'(len); AWSIZE = 3'(size); AWBURST = 2'(bt);
    wait_for(0, {tag, "_aw"});
    @(posedge ACLK); #1;
    AWVALID = 1'b0;

    for (int i = 0; i < nb; i++) begin
      WVALID = 1'b1;
      WID    = (i == bad_beat) ? ~id : id;
      WDATA  = $urandom;
      WSTRB  = 4'($urandom);
      WLAST  = (i == wlast_beat);
      if (i != bad_beat) exp_q.push_back('{model_addr(addr, size, len, bt, i), WDATA, WSTRB});
      wait_for(1, {tag, "_w"});
      @(posedge ACLK); #1;
      WVALID = 1'b0;
      WLAST  = 1'b0;
      if (i == stall_beat) begin
        rdy_force = 1'b1;
        for (int c = 0; c < 3; c++) begin
          @(negedge ACLK);
          chk({tag, "_stall_valid"}, 64'(dev_valid), 64'd1);
          chk({tag, "_stall_addr"}, 64'(dev_addr), 64'(exp_q[$].addr));
          chk({tag, "_stall_data"}, 64'(dev_data), 64'(exp_q[$].data));
          chk({tag, "_stall_wready"}, 64'(WREADY), 64'd0);
        end
        @(posedge ACLK); #1;
        rdy_force = 1'b0;
      end
    end

    if (bready_dly < 0) BREADY = 1'b1;
    wait_for(2, {tag, "_b"});
    chk({tag, "_bid"}, 64'(BID), 64'(id));
    chk({tag, "_bresp"}, 64'(BRESP), err ? 64'd2 : 64'd0);
    if (bready_dly >= 0) begin
      for (int c = 0; c < bready_dly; c++) begin
        @(negedge ACLK);
        chk({tag, "_hold_bvalid"}, 64'(BVALID), 64'd1);
        chk({tag, "_hold_bid"}, 64'(BID), 64'(id));
        chk({tag, "_hold_bresp"}, 64'(BRESP), err ? 64'd2 : 64'd0);
      end
      @(posedge ACLK); #1;
      BREADY = 1'b1;
      @(negedge ACLK);
      chk({tag, "_awready_before"}, 64'(AWREADY), 64'd0);
    end
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    @(negedge ACLK);
    chk({tag, "_bvalid_done"}, 64'(BVALID), 64'd0);
    chk({tag, "_awready_after"}, 64'(AWREADY), 64'd1);

    chk({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    foreach (exp_q[k]) begin
      if (k < got_q.size()) begin
        if (chk_addr) chk($sformatf("%s_addr%0d", tag, k), 64'(got_q[k].addr), 64'(exp_q[k].addr));
        chk($sformatf("%s_data%0d", tag, k), 64'(got_q[k].data), 64'(exp_q[k].data));
        chk($sformatf("%s_strb%0d", tag, k), 64'(got_q[k].strb), 64'(exp_q[k].strb));
      end
    end
  endtask

  initial begin
    int bt, size, len, bad, wl, dly;
    logic [31:0] a;

    #12;
    chk("rst_awready", 64'(AWREADY), 64'd1);
    chk("rst_wready", 64'(WREADY), 64'd0);
    chk("rst_bvalid", 64'(BVALID), 64'd0);
    chk("rst_bid", 64'(BID), 64'd0);
    chk("rst_bresp", 64'(BRESP), 64'd0);
    chk("rst_dev_valid", 64'(dev_valid), 64'd0);
    chk("rst_dev_addr", 64'(dev_addr), 64'd0);
    chk("rst_dev_data", 64'(dev_data), 64'd0);
    chk("rst_dev_strb", 64'(dev_strb), 64'd0);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;

    do_burst(2'd1, 32'h100, 3, 2, 1, -1, 3, 0, -1, 1'b1, "incr");
    do_burst(2'd3, 32'h38, 3, 2, 2, -1, 3, 0, -1, 1'b1, "wrap");
    do_burst(2'd0, 32'h20, 2, 2, 0, -1, 2, 0, 1, 1'b1, "fixed_stall");
    do_burst(2'd1, 32'h200, 3, 2, 1, -1, 1, 0, -1, 1'b1, "early_wlast");
    do_burst(2'd2, 32'h300, 3, 2, 1, 1, 3, 0, -1, 1'b1, "bad_wid");
    do_burst(2'd3, 32'h400, 1, 1, 1, -1, 1, 5, -1, 1'b1, "bready_slow");
    do_burst(2'd2, 32'h500, 0, 0, 1, -1, 0, -1, -1, 1'b1, "bready_early");
    do_burst(2'd1, 32'h40, 2, 2, 2, -1, 2, 0, -1, 1'b0, "wrap_badlen");
    do_burst(2'd0, 32'h44, 3, 3, 1, -1, 3, 0, -1, 1'b1, "bad_size");

    // reset while a beat is held in DEV
    @(posedge ACLK); #1;
    rdy_force = 1'b1;
    AWVALID = 1'b1; AWID = 2'd1; AWADDR = 32'h600; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'd1;
    wait_for(0, "rst_mid_aw");
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    WVALID = 1'b1; WID = 2'd1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WLAST = 1'b0;
    wait_for(1, "rst_mid_w");
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    wait_for(3, "rst_mid_dev");
    #2;
    ARESETn = 1'b0;
    #1;
    chk("rst_mid_dev_valid", 64'(dev_valid), 64'd0);
    chk("rst_mid_wready", 64'(WREADY), 64'd0);
    chk("rst_mid_bvalid", 64'(BVALID), 64'd0);
    chk("rst_mid_awready", 64'(AWREADY), 64'd1);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    rdy_force = 1'b0;
    @(negedge ACLK);
    chk("rst_rel_awready", 64'(AWREADY), 64'd1);
    chk("rst_rel_dev_valid", 64'(dev_valid), 64'd0);

    rand_en = 1'b1;
    for (int t = 0; t < 30; t++) begin
      bt   = int'($urandom_range(0, 3));
      size = int'($urandom_range(0, 3));
      if (bt == 2) begin
        case ($urandom_range(0, 3))
          0: len = 1;
          1: len = 3;
          2: len = 7;
          default: len = 15;
        endcase
      end else begin
        len = int'($urandom_range(0, 15));
      end
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << size) - 32'd1);
      bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len)) : -1;
      wl  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : len;
      dly = int'($urandom_range(0, 3)) - 1;
      do_burst(2'($urandom), a, len, size, bt, bad, wl, dly, -1, bt != 3,
               $sformatf("rnd%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
